// File: rtl/ntt_pkg.sv
// ntt_pkg -- shared definitions for the NTT front-end packer.
//
// Holds the default coefficient geometry (DATA_WIDTH, LANES, BEATS_PER_POLY),
// the NTT modulus, the coefficient type coeff_t and the packer state enum.
// Related build option: NTT_PACKER_REDUCE_EN (consumed by ntt_mod_reduce).
package ntt_pkg;

  localparam int DATA_WIDTH     = 28;
  localparam int LANES          = 32;
  localparam int BEATS_PER_POLY = 128;

  // Modulus must exceed 2^(DATA_WIDTH-1) so that one subtraction is enough
  // to bring any DATA_WIDTH-bit value into [0, MODULUS).
  localparam logic [DATA_WIDTH-1:0] MODULUS = 28'd268369921;

  typedef logic [DATA_WIDTH-1:0] coeff_t;

  // S_FILL: collecting coefficients into staging.
  // S_HOLD: staging holds a finished beat that the output cannot yet take.
  typedef enum logic [0:0] {
    S_FILL = 1'b0,
    S_HOLD = 1'b1
  } pack_state_t;

endpackage

// File: rtl/ntt_mod_reduce.sv
// ntt_mod_reduce -- combinational conditional subtraction of the modulus.
//
// Build option NTT_PACKER_REDUCE_EN:
//   defined   : y = (x >= MODULUS) ? x - MODULUS : x
//   undefined : y = x
//
// Ports:
//   x : input  coeff_t  raw coefficient
//   y : output coeff_t  coefficient after optional reduction
module ntt_mod_reduce
  import ntt_pkg::*;
#(
  parameter coeff_t MODULUS = ntt_pkg::MODULUS
) (
  input  coeff_t x,
  output coeff_t y
);

  localparam coeff_t HALF_RANGE = coeff_t'(1) << (DATA_WIDTH - 1);

  // A modulus at or below half the range would need more than one subtraction.
  if (MODULUS <= HALF_RANGE) begin : g_bad_modulus
    $error("ntt_mod_reduce: MODULUS must exceed 2^(DATA_WIDTH-1)");
  end

`ifdef NTT_PACKER_REDUCE_EN
  // Single conditional subtraction into the range [0, MODULUS).
  always_comb begin
    if (x >= MODULUS) begin
      y = x - MODULUS;
    end else begin
      y = x;
    end
  end
`else
  // Reduction disabled: coefficients pass straight through.
  always_comb begin
    y = x;
  end
`endif

endmodule

// File: rtl/ntt_input_packer.sv
// ntt_input_packer -- packs a serial coefficient stream into wide NTT beats.
//
// Each accepted coefficient is written to staging lane lane_cnt. A beat is
// finished by lane LANES-1 or by s_last; it moves to the output register in
// the same edge when that register is free, otherwise it waits in staging
// (S_HOLD) with s_ready low until the output handshake.
// Build option NTT_PACKER_REDUCE_EN: reduce coefficients >= MODULUS.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   s_valid/s_ready   : serial coefficient handshake
//   s_data, s_last    : coefficient, last coefficient of a polynomial
//   m_valid/m_ready   : beat handshake towards NTT_Top
//   m_data            : LANES coefficients, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   m_sop, m_eop      : first / last beat of a polynomial
//   err_last          : one-cycle pulse on a framing error
//   poly_count        : completed polynomials (wraps at 2^16)
module ntt_input_packer
  import ntt_pkg::*;
#(
  parameter int                    DATA_WIDTH     = ntt_pkg::DATA_WIDTH,
  parameter int                    LANES          = ntt_pkg::LANES,
  parameter int                    BEATS_PER_POLY = ntt_pkg::BEATS_PER_POLY,
  parameter logic [DATA_WIDTH-1:0] MODULUS        = ntt_pkg::MODULUS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [DATA_WIDTH-1:0]       s_data,
  input  logic                        s_last,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [LANES*DATA_WIDTH-1:0] m_data,
  output logic                        m_sop,
  output logic                        m_eop,
  output logic                        err_last,
  output logic [15:0]                 poly_count
);

  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int BEAT_W = (BEATS_PER_POLY > 1) ? $clog2(BEATS_PER_POLY) : 1;

  pack_state_t state_r, state_next_s;

  logic [LANES-1:0][DATA_WIDTH-1:0] stage_r;
  logic [LANES-1:0][DATA_WIDTH-1:0] beat_s;
  logic [LANES-1:0][DATA_WIDTH-1:0] m_data_r;
  logic [LANE_W-1:0]                lane_cnt_r;
  logic [BEAT_W-1:0]                beat_cnt_r;
  logic                             hold_sop_r;
  logic                             hold_eop_r;
  logic                             m_valid_r;
  logic                             m_sop_r;
  logic                             m_eop_r;
  logic                             err_last_r;
  logic [15:0]                      poly_count_r;

  coeff_t red_s;
  logic   accept_s;
  logic   last_lane_s;
  logic   at_end_s;
  logic   beat_done_s;
  logic   beat_sop_s;
  logic   beat_eop_s;
  logic   out_free_s;
  logic   load_new_s;
  logic   load_held_s;
  logic   stall_s;

  ntt_mod_reduce #(
    .MODULUS (coeff_t'(MODULUS))
  ) u_reduce (
    .x (s_data),
    .y (red_s)
  );

  assign s_ready     = (state_r == S_FILL);
  assign accept_s    = s_valid && s_ready;
  assign last_lane_s = (lane_cnt_r == LANE_W'(LANES - 1));
  assign at_end_s    = last_lane_s && (beat_cnt_r == BEAT_W'(BEATS_PER_POLY - 1));
  assign beat_done_s = accept_s && (last_lane_s || s_last);
  assign beat_sop_s  = (beat_cnt_r == BEAT_W'(0));
  assign beat_eop_s  = s_last || at_end_s;
  // The output register can take a beat when empty or emptying this edge.
  assign out_free_s  = !m_valid_r || m_ready;
  assign load_new_s  = beat_done_s && out_free_s;
  assign stall_s     = beat_done_s && !out_free_s;
  // In S_HOLD the output register is always valid, so m_ready is the handshake.
  assign load_held_s = (state_r == S_HOLD) && m_ready;

  // Completed beat image: staging plus the coefficient accepted this cycle.
  always_comb begin
    beat_s             = stage_r;
    beat_s[lane_cnt_r] = red_s;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_FILL;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state: stall when a beat finishes into a busy output.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_FILL: begin
        if (stall_s) begin
          state_next_s = S_HOLD;
        end else begin
          state_next_s = S_FILL;
        end
      end
      S_HOLD: begin
        if (m_ready) begin
          state_next_s = S_FILL;
        end else begin
          state_next_s = S_HOLD;
        end
      end
      default: state_next_s = S_FILL;
    endcase
  end

  // Output register, poly counter and framing-error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_r    <= 1'b0;
      m_sop_r      <= 1'b0;
      m_eop_r      <= 1'b0;
      m_data_r     <= '0;
      err_last_r   <= 1'b0;
      poly_count_r <= 16'd0;
    end else begin
      // s_last must coincide exactly with the final lane of the final beat.
      err_last_r <= accept_s && (s_last != at_end_s);
      if (load_new_s) begin
        m_data_r  <= beat_s;
        m_sop_r   <= beat_sop_s;
        m_eop_r   <= beat_eop_s;
        m_valid_r <= 1'b1;
        if (beat_eop_s) begin
          poly_count_r <= poly_count_r + 16'd1;
        end
      end else if (load_held_s) begin
        m_data_r  <= stage_r;
        m_sop_r   <= hold_sop_r;
        m_eop_r   <= hold_eop_r;
        m_valid_r <= 1'b1;
        if (hold_eop_r) begin
          poly_count_r <= poly_count_r + 16'd1;
        end
      end else if (m_valid_r && m_ready) begin
        m_valid_r <= 1'b0;
      end
    end
  end

  // Staging register and beat/lane position counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_r    <= '0;
      hold_sop_r <= 1'b0;
      hold_eop_r <= 1'b0;
      lane_cnt_r <= '0;
      beat_cnt_r <= '0;
    end else begin
      if (load_new_s || load_held_s) begin
        stage_r <= '0;
      end else if (stall_s) begin
        stage_r    <= beat_s;
        hold_sop_r <= beat_sop_s;
        hold_eop_r <= beat_eop_s;
      end else if (accept_s) begin
        stage_r[lane_cnt_r] <= red_s;
      end

      // Position advances at completion time; s_ready is low while held.
      if (beat_done_s) begin
        lane_cnt_r <= '0;
        if (beat_eop_s) begin
          beat_cnt_r <= '0;
        end else begin
          beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
        end
      end else if (accept_s) begin
        lane_cnt_r <= lane_cnt_r + LANE_W'(1);
      end
    end
  end

  assign m_valid    = m_valid_r;
  assign m_data     = m_data_r;
  assign m_sop      = m_sop_r;
  assign m_eop      = m_eop_r;
  assign err_last   = err_last_r;
  assign poly_count = poly_count_r;

endmodule

// File: tb/tb_ntt_input_packer.sv
// tb_ntt_input_packer -- self-checking bench for ntt_input_packer.
// A reference model packs accepted coefficients by position index within the
// polynomial; a monitor compares every valid output beat against it.
module tb_ntt_input_packer;

  localparam int DW    = 28;
  localparam int L     = 32;
  localparam int B     = 128;
  localparam int NCOEF = L * B;
  localparam logic [DW-1:0] MOD = 28'd268369921;

  typedef struct {
    logic [L*DW-1:0] data;
    logic            sop;
    logic            eop;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            s_valid;
  logic            s_ready;
  logic [DW-1:0]   s_data;
  logic            s_last;
  logic            m_valid;
  logic            m_ready;
  logic [L*DW-1:0] m_data;
  logic            m_sop;
  logic            m_eop;
  logic            err_last;
  logic [15:0]     poly_count;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;

  beat_t           exp_q[$];
  int              m_idx     = 0;
  logic [L*DW-1:0] m_cur     = '0;
  int              exp_poly  = 0;
  int              exp_err   = 0;
  int              err_seen  = 0;
  int              beats_rx  = 0;
  logic            rand_ready = 1'b0;

  ntt_input_packer dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_sop      (m_sop),
    .m_eop      (m_eop),
    .err_last   (err_last),
    .poly_count (poly_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [L*DW-1:0] obs, input logic [L*DW-1:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_reduce(input logic [DW-1:0] x);
`ifdef NTT_PACKER_REDUCE_EN
    if (x >= MOD) return x - MOD;
    else return x;
`else
    return x;
`endif
  endfunction

  // Reference: coefficient number m_idx of the polynomial goes to beat
  // m_idx/L, lane m_idx%L; s_last is legal only on coefficient NCOEF-1.
  task automatic model_accept(input logic [DW-1:0] x, input logic last);
    int    lane;
    int    beat;
    logic  final_pos;
    beat_t b;
    lane      = m_idx % L;
    beat      = m_idx / L;
    final_pos = (m_idx == NCOEF - 1);
    m_cur[lane*DW +: DW] = ref_reduce(x);
    if (last != final_pos) exp_err++;
    if (last || lane == L - 1) begin
      b.data = m_cur;
      b.sop  = (beat == 0);
      b.eop  = last || final_pos;
      exp_q.push_back(b);
      m_cur = '0;
      if (b.eop) begin
        m_idx = 0;
        exp_poly++;
      end else begin
        m_idx++;
      end
    end else begin
      m_idx++;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_idx    = 0;
    m_cur    = '0;
    exp_poly = 0;
    exp_err  = 0;
    err_seen = 0;
    beats_rx = 0;
  endtask

  task automatic send(input logic [DW-1:0] x, input logic last);
    bit ok;
    ok      = 1'b0;
    s_valid = 1'b1;
    s_data  = x;
    s_last  = last;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      model_accept(x, last);
      @(posedge clk);
      #1;
    end else begin
      total_cnt++;
      fail_cnt++;
      $error("FAIL send_timeout: observed s_ready stuck 0 expected accept");
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check_val("drain_queue_empty", L*DW'(exp_q.size()), '0);
    @(posedge clk);
    #1;
  endtask

  // Output monitor: every valid cycle must show the oldest expected beat.
  always @(negedge clk) begin
    if (!rst) begin
      if (err_last) err_seen++;
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          check_val("beat_expected", '0, L*DW'(1));
        end else begin
          check_val("m_data", m_data, exp_q[0].data);
          check_val("m_sop", L*DW'(m_sop), L*DW'(exp_q[0].sop));
          check_val("m_eop", L*DW'(m_eop), L*DW'(exp_q[0].eop));
          if (m_ready) begin
            void'(exp_q.pop_front());
            beats_rx++;
          end
        end
      end
    end
  end

  // Random backpressure when enabled.
  always @(posedge clk) begin
    #2;
    if (rand_ready) m_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Reset state.
    @(negedge clk);
    check_val("rst_m_valid", L*DW'(m_valid), '0);
    check_val("rst_s_ready", L*DW'(s_ready), L*DW'(1));
    check_val("rst_poly_count", L*DW'(poly_count), '0);
    check_val("rst_err_last", L*DW'(err_last), '0);
    check_val("rst_m_data", m_data, '0);
    check_val("rst_m_sop_eop", L*DW'({m_sop, m_eop}), '0);
    @(posedge clk);
    #1;

    // Full polynomial 0..4095, no backpressure.
    for (int i = 0; i < NCOEF; i++) send(DW'(i), i == NCOEF - 1);
    drain();
    check_val("full_beats", L*DW'(beats_rx), L*DW'(128));
    check_val("full_poly_count", L*DW'(poly_count), L*DW'(1));
    check_val("full_err_none", L*DW'(err_seen), '0);

    // Backpressure on beats 0-1, then random backpressure to the end.
    m_ready = 1'b0;
    for (int i = 0; i < 2 * L; i++) send(DW'($urandom), 1'b0);
    @(negedge clk);
    check_val("hold_s_ready", L*DW'(s_ready), '0);
    check_val("hold_m_valid", L*DW'(m_valid), L*DW'(1));
    check_val("hold_m_sop", L*DW'(m_sop), L*DW'(1));
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    m_ready    = 1'b1;
    rand_ready = 1'b1;
    for (int i = 2 * L; i < NCOEF; i++) send(DW'($urandom), i == NCOEF - 1);
    rand_ready = 1'b0;
    m_ready    = 1'b1;
    drain();
    check_val("bp_beats", L*DW'(beats_rx), L*DW'(256));
    check_val("bp_poly_count", L*DW'(poly_count), L*DW'(exp_poly));
    check_val("bp_err_none", L*DW'(err_seen), L*DW'(exp_err));

    // Beat completion coinciding with an output handshake.
    m_ready = 1'b0;
    for (int i = 0; i < 2 * L - 1; i++) send(DW'($urandom), 1'b0);
    m_ready = 1'b1;
    send(DW'($urandom), 1'b0);
    @(negedge clk);
    check_val("coinc_s_ready", L*DW'(s_ready), L*DW'(1));
    check_val("coinc_m_valid", L*DW'(m_valid), L*DW'(1));
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) send(DW'($urandom), i == 4);
    drain();
    check_val("coinc_err", L*DW'(err_seen), L*DW'(exp_err));

    // Early s_last on the 40th coefficient, then a one-coefficient polynomial.
    for (int i = 0; i < 40; i++) send(DW'(1000 + i), i == 39);
    send(DW'(77), 1'b1);
    drain();
    check_val("early_err", L*DW'(err_seen), L*DW'(exp_err));
    check_val("early_poly_count", L*DW'(poly_count), L*DW'(exp_poly));

    // Modulus boundary values.
    send(28'd268369925, 1'b0);
    send(28'd268369920, 1'b0);
    send(28'd268369921, 1'b1);
    drain();
    check_val("mod_poly_count", L*DW'(poly_count), L*DW'(exp_poly));

    // Reset with a beat held in the output and 17 coefficients in staging.
    m_ready = 1'b0;
    for (int i = 0; i < L + 17; i++) send(DW'($urandom), 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    m_ready = 1'b1;
    @(negedge clk);
    check_val("midrst_m_valid", L*DW'(m_valid), '0);
    check_val("midrst_poly_count", L*DW'(poly_count), '0);
    check_val("midrst_s_ready", L*DW'(s_ready), L*DW'(1));
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) send(DW'(500 + i), i == 2);
    drain();
    check_val("post_rst_beats", L*DW'(beats_rx), L*DW'(1));
    check_val("post_rst_poly_count", L*DW'(poly_count), L*DW'(1));
    check_val("post_rst_err", L*DW'(err_seen), L*DW'(1));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
